// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch / decode / execute for ALU ops, BR, JMP and an optional PAUSE op.
// The PAUSE op and its handshake states are built only when PAUSE_OP_EN is defined.
module control_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       Mem_OE,
  output logic [1:0] PCMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK
);

  typedef enum logic [3:0] {
    HALTED, S18, S33_1, S33_2, S35, S32, S01, S05, S09, S00, S22, S12
`ifdef PAUSE_OP_EN
    , PAUSE1, PAUSE2
`endif
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= HALTED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALTED: if (Run) state_d = S18;
      S18:    state_d = S33_1;
      S33_1:  state_d = S33_2;
      S33_2:  state_d = S35;
      S35:    state_d = S32;
      S32: begin
        case (Opcode)
          4'b0001: state_d = S01;
          4'b0101: state_d = S05;
          4'b1001: state_d = S09;
          4'b0000: state_d = S00;
          4'b1100: state_d = S12;
`ifdef PAUSE_OP_EN
          4'b1101: state_d = PAUSE1;
`endif
          default: state_d = S18;
        endcase
      end
      S01, S05, S09, S22, S12: state_d = S18;
      // BEN was loaded in S32, so it is only valid to look at it here.
      S00: state_d = BEN ? S22 : S18;
`ifdef PAUSE_OP_EN
      PAUSE1: if (Continue)  state_d = PAUSE2;
      PAUSE2: if (!Continue) state_d = S18;
`endif
      default: state_d = HALTED;
    endcase
  end

`ifndef PAUSE_OP_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  always_comb begin
    LD_MAR   = 1'b0;
    LD_MDR   = 1'b0;
    LD_IR    = 1'b0;
    LD_BEN   = 1'b0;
    LD_CC    = 1'b0;
    LD_REG   = 1'b0;
    LD_PC    = 1'b0;
    GatePC   = 1'b0;
    GateMDR  = 1'b0;
    GateALU  = 1'b0;
    Mem_OE   = 1'b0;
    PCMUX    = 2'b00;
    ADDR1MUX = 1'b0;
    ADDR2MUX = 2'b00;
    ALUK     = 2'b00;
    case (state_q)
      S18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
        PCMUX  = 2'b00;
      end
      S33_1: Mem_OE = 1'b1;
      S33_2: begin
        Mem_OE = 1'b1;
        LD_MDR = 1'b1;
      end
      S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      S01, S05, S09: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        ALUK    = (state_q == S01) ? 2'b00 : (state_q == S05) ? 2'b01 : 2'b10;
      end
      S22: begin
        ADDR1MUX = 1'b0;
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S12: begin
        ADDR1MUX = 1'b1;
        ADDR2MUX = 2'b00;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; states are identified by their output patterns.
module tb_control_sequencer;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic       GatePC, GateMDR, GateALU, Mem_OE, ADDR1MUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .Mem_OE(Mem_OE), .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK)
  );

  always #5 Clk = ~Clk;

  // Bit positions of the packed output word used for expected values.
  localparam logic [17:0] B_LD_MAR = 18'd1 << 17;
  localparam logic [17:0] B_LD_MDR = 18'd1 << 16;
  localparam logic [17:0] B_LD_IR  = 18'd1 << 15;
  localparam logic [17:0] B_LD_BEN = 18'd1 << 14;
  localparam logic [17:0] B_LD_CC  = 18'd1 << 13;
  localparam logic [17:0] B_LD_REG = 18'd1 << 12;
  localparam logic [17:0] B_LD_PC  = 18'd1 << 11;
  localparam logic [17:0] B_GPC    = 18'd1 << 10;
  localparam logic [17:0] B_GMDR   = 18'd1 << 9;
  localparam logic [17:0] B_GALU   = 18'd1 << 8;
  localparam logic [17:0] B_MEM    = 18'd1 << 7;
  localparam logic [17:0] B_PCM_AD = 18'd1 << 6;
  localparam logic [17:0] B_A1_BR  = 18'd1 << 4;
  localparam logic [17:0] B_A2_OF  = 18'd1 << 3;
  localparam logic [17:0] B_ALU_AN = 18'd1 << 0;
  localparam logic [17:0] B_ALU_NT = 18'd1 << 1;

  localparam logic [17:0] E_IDLE  = 18'd0;
  localparam logic [17:0] E_S18   = B_LD_MAR | B_LD_PC | B_GPC;
  localparam logic [17:0] E_S33_1 = B_MEM;
  localparam logic [17:0] E_S33_2 = B_MEM | B_LD_MDR;
  localparam logic [17:0] E_S35   = B_GMDR | B_LD_IR;
  localparam logic [17:0] E_S32   = B_LD_BEN;
  localparam logic [17:0] E_S01   = B_GALU | B_LD_REG | B_LD_CC;
  localparam logic [17:0] E_S05   = E_S01 | B_ALU_AN;
  localparam logic [17:0] E_S09   = E_S01 | B_ALU_NT;
  localparam logic [17:0] E_S22   = B_PCM_AD | B_A2_OF | B_LD_PC;
  localparam logic [17:0] E_S12   = B_PCM_AD | B_A1_BR | B_LD_PC;

  logic [17:0] observed;
  assign observed = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                     GatePC, GateMDR, GateALU, Mem_OE, PCMUX, ADDR1MUX, ADDR2MUX, ALUK};

  task automatic checkOutput(input string tag, input logic [17:0] expected);
    logic [2:0] gates;
    gates = {GatePC, GateMDR, GateALU};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %05h expected %05h", tag, observed, expected);
    end
    checks++;
    assert ($countones(gates) <= 1) else begin
      errors++;
      $error("[TB] FAIL %s_gate_onehot observed %03b expected at most one set", tag, gates);
    end
  endtask

  // One rising edge, then settle before sampling or changing inputs.
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
  endtask

  // From S18, walk the fetch and land in S32.
  task automatic fetchInstr(input string tag);
    applyStimulus(); checkOutput({tag, "_S33_1"}, E_S33_1);
    applyStimulus(); checkOutput({tag, "_S33_2"}, E_S33_2);
    applyStimulus(); checkOutput({tag, "_S35"},   E_S35);
    applyStimulus(); checkOutput({tag, "_S32"},   E_S32);
  endtask

  initial begin
    Reset = 1'b0; Run = 1'b1; Continue = 1'b0; BEN = 1'b0; Opcode = 4'b0001;
    repeat (3) applyStimulus();
    checkOutput("reset_halted", E_IDLE);

    Run = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    applyStimulus(); checkOutput("halted_no_run", E_IDLE);
    applyStimulus(); checkOutput("halted_no_run2", E_IDLE);

    Run = 1'b1;
    applyStimulus(); checkOutput("run_S18", E_S18);
    fetchInstr("add");
    applyStimulus(); checkOutput("add_S01", E_S01);
    applyStimulus(); checkOutput("add_S18", E_S18);

    Opcode = 4'b0101; Run = 1'b0;
    fetchInstr("and");
    applyStimulus(); checkOutput("and_S05", E_S05);
    applyStimulus(); checkOutput("and_S18", E_S18);

    Opcode = 4'b1001; Run = 1'b1;
    fetchInstr("not");
    applyStimulus(); checkOutput("not_S09", E_S09);
    applyStimulus(); checkOutput("not_S18", E_S18);

    Opcode = 4'b0000; BEN = 1'b0;
    fetchInstr("brt");
    BEN = 1'b1;
    applyStimulus(); checkOutput("brt_S00", E_IDLE);
    applyStimulus(); checkOutput("brt_S22", E_S22);
    applyStimulus(); checkOutput("brt_S18", E_S18);

    BEN = 1'b1;
    fetchInstr("brn");
    BEN = 1'b0;
    applyStimulus(); checkOutput("brn_S00", E_IDLE);
    applyStimulus(); checkOutput("brn_S18", E_S18);

    Opcode = 4'b1100;
    fetchInstr("jmp");
    applyStimulus(); checkOutput("jmp_S12", E_S12);
    applyStimulus(); checkOutput("jmp_S18", E_S18);

    Opcode = 4'b1111;
    fetchInstr("bad");
    applyStimulus(); checkOutput("bad_S18", E_S18);

    Opcode = 4'b1101; Continue = 1'b0;
    fetchInstr("pause");
`ifdef PAUSE_OP_EN
    for (int i = 0; i < 10; i++) begin
      applyStimulus(); checkOutput("pause_hold1", E_IDLE);
    end
    Continue = 1'b1;
    applyStimulus(); checkOutput("pause_P2", E_IDLE);
    applyStimulus(); checkOutput("pause_hold2", E_IDLE);
    Continue = 1'b0;
    applyStimulus(); checkOutput("pause_S18", E_S18);
`else
    Continue = 1'b1;
    applyStimulus(); checkOutput("pause_off_S18", E_S18);
    Continue = 1'b0;
`endif

    Opcode = 4'b0001; Run = 1'b1;
    applyStimulus(); checkOutput("rst_S33_1", E_S33_1);
    applyStimulus(); checkOutput("rst_S33_2", E_S33_2);
    Reset = 1'b0;
    #1; checkOutput("rst_async_halted", E_IDLE);
    applyStimulus(); checkOutput("rst_held_halted", E_IDLE);
    @(negedge Clk); Reset = 1'b1;
    #1; checkOutput("rst_release_halted", E_IDLE);
    applyStimulus(); checkOutput("rst_restart_S18", E_S18);
    applyStimulus(); checkOutput("rst_restart_S33_1", E_S33_1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
